// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: elastic-register FSM states and the default bubble instruction.
package cpu_pipe_pkg;

    localparam int unsigned DEF_INSTR_W = 32;

    // All-zero by default; instances may override with a real ISA NOP encoding.
    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_CNT = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_elastic_reg.sv
// IF/ID boundary register: valid/ready handshake, one skid entry behind the output register,
// flush-to-bubble and a saturating count of stalled output cycles.
module if_id_elastic_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned            PC_W        = 32,
    parameter int unsigned            INSTR_W     = 32,
    parameter logic [INSTR_W-1:0]     NOP_INSTR   = INSTR_W'(DEF_NOP_INSTR),
    parameter int unsigned            STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_incr_in,
    input  logic [INSTR_W-1:0]     instr_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc_incr_out,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e          state;
    pipe_state_e          state_nxt;
    logic [PC_W-1:0]      main_pc_nxt;
    logic [INSTR_W-1:0]   main_instr_nxt;
    logic [PC_W-1:0]      skid_pc;
    logic [INSTR_W-1:0]   skid_instr;
    logic [PC_W-1:0]      skid_pc_nxt;
    logic [INSTR_W-1:0]   skid_instr_nxt;
    logic                 push;
    logic                 pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // State, output (main) and skid registers; handshake flags track the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            pc_incr_out <= '0;
            instr_out   <= NOP_INSTR;
            skid_pc     <= '0;
            skid_instr  <= NOP_INSTR;
        end else begin
            state       <= state_nxt;
            out_valid   <= (state_nxt != EMPTY);
            in_ready    <= (state_nxt != FULL);
            pc_incr_out <= main_pc_nxt;
            instr_out   <= main_instr_nxt;
            skid_pc     <= skid_pc_nxt;
            skid_instr  <= skid_instr_nxt;
        end
    end

    // Next-state and datapath steering; flush drops everything, including this cycle's input.
    always_comb begin
        state_nxt      = state;
        main_pc_nxt    = pc_incr_out;
        main_instr_nxt = instr_out;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;

        if (flush) begin
            state_nxt      = EMPTY;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP_INSTR;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt      = BUSY;
                        main_pc_nxt    = pc_incr_in;
                        main_instr_nxt = instr_in;
                    end
                end
                BUSY: begin
                    if (push && pop) begin
                        main_pc_nxt    = pc_incr_in;
                        main_instr_nxt = instr_in;
                    end else if (push) begin
                        state_nxt      = FULL;
                        skid_pc_nxt    = pc_incr_in;
                        skid_instr_nxt = instr_in;
                    end else if (pop) begin
                        state_nxt      = EMPTY;
                        main_pc_nxt    = '0;
                        main_instr_nxt = NOP_INSTR;
                    end
                end
                FULL: begin
                    // Skid entry is older than anything that can arrive later.
                    if (pop) begin
                        state_nxt      = BUSY;
                        main_pc_nxt    = skid_pc;
                        main_instr_nxt = skid_instr;
                        skid_pc_nxt    = '0;
                        skid_instr_nxt = NOP_INSTR;
                    end
                end
                default: begin
                    state_nxt      = EMPTY;
                    main_pc_nxt    = '0;
                    main_instr_nxt = NOP_INSTR;
                    skid_pc_nxt    = '0;
                    skid_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// Directed bench for if_id_elastic_reg: vector table plus stall-counter saturation sequence.
module tb_if_id_elastic_reg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned STALL_CNT_W = 4;
    localparam logic [INSTR_W-1:0] NOP  = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] TAG  = 32'hC0DE_0000;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [PC_W-1:0]        pc_incr_in;
    logic [INSTR_W-1:0]     instr_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_W-1:0]        pc_incr_out;
    logic [INSTR_W-1:0]     instr_out;
    logic [STALL_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    if_id_elastic_reg #(
        .PC_W        (PC_W),
        .INSTR_W     (INSTR_W),
        .NOP_INSTR   (NOP),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_incr_in  (pc_incr_in),
        .instr_in    (instr_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_incr_out (pc_incr_out),
        .instr_out   (instr_out),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        int          e_stall;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic ordy);
        reset      = rst;
        flush      = fl;
        in_valid   = iv;
        pc_incr_in = pc;
        instr_in   = TAG | pc;
        out_ready  = ordy;
    endtask

    task automatic check_outputs(input int step, input logic e_ov, input logic e_ir,
                                 input logic [31:0] e_pc, input int e_stall);
        logic [31:0] e_instr;
        e_instr = e_ov ? (TAG | e_pc) : NOP;
        check("out_valid", step, 32'(out_valid), 32'(e_ov));
        check("in_ready",  step, 32'(in_ready),  32'(e_ir));
        check("pc_incr_out", step, pc_incr_out, e_pc);
        check("instr_out", step, instr_out, e_instr);
        check("stall_cnt", step, 32'(stall_cnt), 32'(e_stall));
    endtask

    initial begin
        //         rst   fl    iv    pc        ordy  e_ov  e_ir  e_pc      stall
        // reset held for two cycles
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h00, 0};
        // streaming 4, 8, 12 then drain
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 1'b1, 1'b1, 32'h04, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 1'b1, 32'h08, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h0C, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 0};
        // back-pressure: 0x10, 0x14 fill; 0x99 refused while full; drain in order
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 32'h10, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h10, 2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h14, 2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2};
        // flush while full with in_valid (0x18 discarded)
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20, 2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 32'h20, 3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h00, 4};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 4};
        // flush coinciding with pop and a new input
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b0, 1'b1, 1'b1, 32'h28, 4};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h2C, 1'b1, 1'b0, 1'b1, 32'h00, 4};
        // reset in BUSY with push and pop active
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 1'b1, 32'h30, 4};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 32'h34, 1'b1, 1'b0, 1'b1, 32'h00, 0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 0};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_stall);
        end

        // Saturation: one entry held with out_ready low; counter stops at 15.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(100, 1'b1, 1'b1, 32'h40, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check_outputs(100 + k, 1'b1, 1'b1, 32'h40, (k < 15) ? k : 15);
        end
        // Drain keeps the saturated count; only reset clears it.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs(121, 1'b0, 1'b1, 32'h00, 15);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(122, 1'b0, 1'b1, 32'h00, 15);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(123, 1'b0, 1'b1, 32'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
